// File: rtl/risc_pkg.sv
// Shared definitions for the instruction fetch slice.
// Holds the datapath word width, the default reset PC and the fetch FSM
// state encoding used by fetch_unit and pc_register.
package risc_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter register with increment / jump-load selection.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset, loads RESET_PC
//   inc_en    - advance pc by PC_STEP (32-bit modulo)
//   load_en   - load pc from load_addr; wins over inc_en
//   load_addr - jump target
//   pc        - current program counter
module pc_register
  import risc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned       PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_en,
  input  logic              load_en,
  input  logic [WORD_W-1:0] load_addr,
  output logic [WORD_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= load_addr;
    end else if (inc_en) begin
      pc <= pc + WORD_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction
// memory, registers it for the control decoder, holds it while downstream
// stalls and redirects the PC when the decoder flags a jump.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_count output
// (number of consumed instructions, wraps at 2^32).
//
// Ports:
//   clk, rst               - clock / asynchronous active-high reset
//   imem_req, imem_addr    - memory read request and address (= pc)
//   imem_ack, imem_data    - memory data valid strobe and instruction word
//   instr, instr_valid,
//   instr_pc               - registered instruction, live flag, fetch address
//   stall                  - downstream cannot consume
//   jmp_flag, jmp_address  - decoder jump request and target
//   fetch_count            - consumed-instruction counter (FETCH_PERF_CNT_EN)
module fetch_unit
  import risc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned       PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_data,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr_pc,
  input  logic              stall,
  input  logic              jmp_flag,
  input  logic [WORD_W-1:0] jmp_address
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [WORD_W-1:0] fetch_count
`endif
);

  fetch_state_t      state;
  logic [WORD_W-1:0] pc;
  logic              accept;
  logic              consume;

  // imem_req is a registered output that is low in reset, so the first cycle
  // after release carries no request and a stale ack from an aborted fetch
  // cannot be captured. Only an ack against a live request is accepted.
  assign accept  = (state == FETCH) && imem_req && imem_ack;
  assign consume = (state == ISSUE) && !stall;

  pc_register #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_register (
    .clk       (clk),
    .rst       (rst),
    .inc_en    (accept),
    .load_en   (consume && jmp_flag),
    .load_addr (jmp_address),
    .pc        (pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (accept) begin
            instr       <= imem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= ISSUE;
          end else begin
            imem_req    <= 1'b1;
          end
        end
        ISSUE: begin
          // imem_ack is ignored here; instr stays put until consumed.
          if (!stall) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (consume) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: sequential fetch, delayed
// ack, jump, stall with pending jump, PC wrap and reset abort.
// Define FETCH_PERF_CNT_EN to also exercise the fetch_count output.
module tb_fetch_unit;
  import risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        stall;
  logic        jmp_flag;
  logic [31:0] jmp_address;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  logic        ovr_en;
  logic [31:0] ovr_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  // Memory model: word at address a holds a*4 unless overridden.
  always_comb imem_data = ovr_en ? ovr_data : (imem_addr << 2);

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .stall       (stall),
    .jmp_flag    (jmp_flag),
    .jmp_address (jmp_address)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; jmp_flag = 1'b0;
    jmp_address = '0; ovr_en = 1'b0; ovr_data = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_req",   32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_ipc",   instr_pc, 32'd0);
    check_eq("rst_addr",  imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("rst_cnt",   fetch_count, 32'd0);
`endif

    // Back-to-back fetch with ack always high: one instruction per 2 cycles.
    rst = 1'b0; imem_ack = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("seq_req1",  32'(imem_req), 32'd1);
      check_eq("seq_addr",  imem_addr, 32'(i));
      check_eq("seq_val0",  32'(instr_valid), 32'd0);
      @(negedge clk);
      check_eq("seq_val1",  32'(instr_valid), 32'd1);
      check_eq("seq_instr", instr, 32'(i * 4));
      check_eq("seq_ipc",   instr_pc, 32'(i));
      check_eq("seq_req0",  32'(imem_req), 32'd0);
      @(negedge clk);
    end

    // Ack withheld for 5 cycles.
    imem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("wait_req",  32'(imem_req), 32'd1);
      check_eq("wait_addr", imem_addr, 32'd3);
      check_eq("wait_val",  32'(instr_valid), 32'd0);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    check_eq("late_val",   32'(instr_valid), 32'd1);
    check_eq("late_instr", instr, 32'd12);
    check_eq("late_ipc",   instr_pc, 32'd3);
    imem_ack = 1'b0;
    @(negedge clk);
    check_eq("nxt_addr", imem_addr, 32'd4);

    // Jump instruction (opcode 2) fetched, then taken on consumption.
    ovr_en = 1'b1; ovr_data = 32'h0800_0010; imem_ack = 1'b1;
    @(negedge clk);
    check_eq("jmp_instr", instr, 32'h0800_0010);
    check_eq("jmp_ipc",   instr_pc, 32'd4);
    imem_ack = 1'b0; ovr_en = 1'b0; jmp_flag = 1'b1; jmp_address = 32'h40;
    @(negedge clk);
    check_eq("jmp_addr", imem_addr, 32'h40);
    check_eq("jmp_req",  32'(imem_req), 32'd1);
    // jmp_flag held high during FETCH must not redirect.
    jmp_address = 32'h80; imem_ack = 1'b1;
    @(negedge clk);
    check_eq("tgt_ipc",   instr_pc, 32'h40);
    check_eq("tgt_instr", instr, 32'h100);
    jmp_flag = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    check_eq("nojmp_addr", imem_addr, 32'h41);

    // Stall for 3 cycles with a pending jump and a stray ack.
    imem_ack = 1'b1;
    @(negedge clk);
    check_eq("stl_instr0", instr, 32'h104);
    stall = 1'b1; jmp_flag = 1'b1; jmp_address = 32'h200;
    ovr_en = 1'b1; ovr_data = 32'hBAD0_0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("stl_instr", instr, 32'h104);
      check_eq("stl_val",   32'(instr_valid), 32'd1);
      check_eq("stl_req",   32'(imem_req), 32'd0);
      check_eq("stl_addr",  imem_addr, 32'h42);
    end
    stall = 1'b0; imem_ack = 1'b0; ovr_en = 1'b0;
    @(negedge clk);
    check_eq("stl_jaddr", imem_addr, 32'h200);
    check_eq("stl_jreq",  32'(imem_req), 32'd1);
    check_eq("stl_jval",  32'(instr_valid), 32'd0);
    jmp_flag = 1'b0;

    // PC wrap at the top of the address space.
    imem_ack = 1'b1;
    @(negedge clk);
    check_eq("w_instr", instr, 32'h800);
    imem_ack = 1'b0; jmp_flag = 1'b1; jmp_address = 32'hFFFF_FFFF;
    @(negedge clk);
    check_eq("w_addr_top", imem_addr, 32'hFFFF_FFFF);
    jmp_flag = 1'b0; imem_ack = 1'b1;
    @(negedge clk);
    check_eq("w_ipc",   instr_pc, 32'hFFFF_FFFF);
    check_eq("w_instr", instr, 32'hFFFF_FFFC);
    imem_ack = 1'b0;
    @(negedge clk);
    check_eq("w_addr0", imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("cnt9", fetch_count, 32'd9);
`endif

    // Reset asserted mid-wait, then a late ack right after release.
    @(negedge clk);
    check_eq("pre_rst_req", 32'(imem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_req",   32'(imem_req), 32'd0);
    check_eq("ar_val",   32'(instr_valid), 32'd0);
    check_eq("ar_instr", instr, 32'd0);
    check_eq("ar_ipc",   instr_pc, 32'd0);
    check_eq("ar_addr",  imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("ar_cnt",   fetch_count, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0; ovr_en = 1'b1; ovr_data = 32'h1234_5678; imem_ack = 1'b1;
    @(negedge clk);
    check_eq("rf_val0", 32'(instr_valid), 32'd0);
    check_eq("rf_req",  32'(imem_req), 32'd1);
    check_eq("rf_addr", imem_addr, 32'd0);
    @(negedge clk);
    check_eq("rf_val1",  32'(instr_valid), 32'd1);
    check_eq("rf_instr", instr, 32'h1234_5678);
    check_eq("rf_ipc",   instr_pc, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
